// File: rtl/mem_stage.sv
// MEM pipeline stage: owns the data memory, clears it after reset, and
// registers load data, ALU result and write-back control into the MEM/WB word.
module mem_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*DATA_WIDTH+5:0]   pipeline_re_i,
  output logic [2*DATA_WIDTH+4:0]   pipeline_ou,
  output logic [2:0]                mem_op_dest,
  output logic                      mem_busy
);

  localparam int IN_W = 2*DATA_WIDTH + 6;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic [ADDR_WIDTH-1:0]   w_next_cnt;

  logic [DATA_WIDTH-1:0]   w_alu_result;
  logic                    w_mem_writ_en;
  logic [DATA_WIDTH-1:0]   w_mem_writ_data;
  logic [4:0]              w_wb_ctrl;
  logic [ADDR_WIDTH-1:0]   w_addr;

  logic                    w_we;
  logic [ADDR_WIDTH-1:0]   w_waddr;
  logic [DATA_WIDTH-1:0]   w_wdata;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  assign w_alu_result    = pipeline_re_i[IN_W-1 -: DATA_WIDTH];
  assign w_mem_writ_en   = pipeline_re_i[DATA_WIDTH+5];
  assign w_mem_writ_data = pipeline_re_i[DATA_WIDTH+4:5];
  assign w_wb_ctrl       = pipeline_re_i[4:0];
  // Upper ALU bits only feed the pass-through field; the address wraps.
  assign w_addr          = w_alu_result[ADDR_WIDTH-1:0];

  assign mem_op_dest = pipeline_re_i[3:1];
  assign mem_busy    = (r_state == ST_CLEAR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_clr_cnt <= w_next_cnt;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_clr_cnt;
    w_we         = 1'b0;
    w_waddr      = w_addr;
    w_wdata      = w_mem_writ_data;
    case (r_state)
      ST_CLEAR: begin
        w_we       = 1'b1;
        w_waddr    = r_clr_cnt;
        w_wdata    = '0;
        w_next_cnt = r_clr_cnt + ADDR_WIDTH'(1);
        if (r_clr_cnt == ADDR_WIDTH'(DEPTH-1)) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        w_we = w_mem_writ_en;
      end
    endcase
  end

  // NOTE: the memory array has no reset branch so it maps onto RAM; its
  // contents are defined instead by the post-reset clear sweep.
  always_ff @(posedge clk) begin
    if (!rst && w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Read samples the pre-edge contents, giving read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (rst || r_state == ST_CLEAR) begin
      pipeline_ou <= '0;
    end else begin
      pipeline_ou <= {r_mem[w_addr], w_alu_result, w_wb_ctrl};
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a reference model of memory and pipeline
// compared every cycle, plus directed vectors with literal expectations.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [37:0] pipeline_re_i;
  logic [36:0] pipeline_ou;
  logic [2:0]  mem_op_dest;
  logic        mem_busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pipeline_re_i (pipeline_re_i),
    .pipeline_ou   (pipeline_ou),
    .mem_op_dest   (mem_op_dest),
    .mem_busy      (mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [37:0] mk(input logic [15:0] alu, input logic we,
                                     input logic [15:0] wd, input logic [4:0] ctrl);
    return {alu, we, wd, ctrl};
  endfunction

  // Reference model: a reset wipes memory and starts a 256-cycle busy window
  // during which the stage emits bubbles; afterwards each cycle reads the old
  // word, registers it with the ALU result and control, then applies any store.
  logic [15:0] m_mem [256];
  int          m_busy_left = 0;
  logic [36:0] m_out       = '0;
  bit          m_valid     = 1'b0;

  always @(posedge clk) begin
    logic [7:0] a;
    if (rst) begin
      m_valid     = 1'b1;
      m_busy_left = 256;
      m_out       = '0;
      for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
    end else if (m_valid) begin
      if (m_busy_left > 0) begin
        m_busy_left = m_busy_left - 1;
        m_out       = '0;
      end else begin
        a     = pipeline_re_i[29:22];
        m_out = {m_mem[a], pipeline_re_i[37:22], pipeline_re_i[4:0]};
        if (pipeline_re_i[21]) m_mem[a] = pipeline_re_i[20:5];
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_pipeline_ou", 64'(pipeline_ou), 64'(m_out));
      check("model_mem_busy",    64'(mem_busy),    64'(m_busy_left != 0));
      check("model_mem_op_dest", 64'(mem_op_dest), 64'(pipeline_re_i[3:1]));
    end
  end

  // Hold an input word across one rising edge; returns just after it.
  task automatic drive(input logic [37:0] w);
    pipeline_re_i = w;
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (mem_busy === 1'b1 && n < 400) begin
      drive(38'h0);
      n++;
    end
    check(name, 64'(n), 64'd256);
  endtask

  initial begin
    rst = 1'b1;
    pipeline_re_i = '0;
    drive(38'h0);
    drive(38'h0);
    check("reset_pipeline_ou", 64'(pipeline_ou), 64'h0);
    check("reset_mem_busy",    64'(mem_busy),    64'h1);

    rst = 1'b0;
    count_busy("clear_busy_cycles");

    drive(mk(16'h007F, 1'b0, 16'h0000, 5'b00001));
    check("load_cleared_7f_data", 64'(pipeline_ou[36:21]), 64'h0000);
    check("load_cleared_7f_ctrl", 64'(pipeline_ou[4:0]),   64'h01);

    drive(mk(16'h0010, 1'b1, 16'hBEEF, 5'b00000));
    drive(mk(16'h0010, 1'b0, 16'h0000, 5'b10111));
    check("store_then_load", 64'(pipeline_ou), 64'({16'hBEEF, 16'h0010, 5'b10111}));

    drive(mk(16'h0020, 1'b1, 16'h1111, 5'b00000));
    drive(mk(16'h0020, 1'b1, 16'h2222, 5'b00000));
    check("rdw_old_data", 64'(pipeline_ou[36:21]), 64'h1111);
    drive(mk(16'h0020, 1'b0, 16'h0000, 5'b00000));
    check("rdw_new_data", 64'(pipeline_ou[36:21]), 64'h2222);

    drive(mk(16'h0305, 1'b1, 16'hA5A5, 5'b00000));
    drive(mk(16'h0005, 1'b0, 16'h0000, 5'b00000));
    check("addr_wrap", 64'(pipeline_ou[36:21]), 64'hA5A5);

    pipeline_re_i = mk(16'h1234, 1'b0, 16'hFFFF, 5'b11010);
    #1;
    check("dest_comb", 64'(mem_op_dest), 64'h5);
    drive(mk(16'h1234, 1'b0, 16'hFFFF, 5'b11010));
    check("alu_passthrough", 64'(pipeline_ou[20:0]), 64'({16'h1234, 5'b11010}));
    check("no_store_when_disabled", 64'(pipeline_ou[36:21]), 64'h0000);

    drive(mk(16'h0100, 1'b1, 16'h5A5A, 5'b00000));
    drive(38'h0);
    check("nop_reads_addr0", 64'(pipeline_ou), 64'({16'h5A5A, 16'h0000, 5'b00000}));

    rst = 1'b1;
    drive(38'h0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) drive(38'h0);
    check("mid_sweep_still_busy", 64'(mem_busy), 64'h1);
    rst = 1'b1;
    drive(38'h0);
    check("mid_sweep_reset_busy", 64'(mem_busy), 64'h1);
    rst = 1'b0;
    count_busy("mid_sweep_restart_busy");
    drive(mk(16'h0010, 1'b0, 16'h0000, 5'b00001));
    check("sweep_cleared_beef", 64'(pipeline_ou[36:21]), 64'h0000);

    drive(mk(16'h0040, 1'b1, 16'h7777, 5'b00000));
    rst = 1'b1;
    drive(mk(16'h0040, 1'b1, 16'hDEAD, 5'b11111));
    check("run_reset_pipeline_ou", 64'(pipeline_ou), 64'h0);
    check("run_reset_busy",        64'(mem_busy),    64'h1);
    rst = 1'b0;
    count_busy("run_reset_busy_cycles");
    drive(mk(16'h0040, 1'b0, 16'h0000, 5'b00000));
    check("run_reset_mem_cleared", 64'(pipeline_ou[36:21]), 64'h0000);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the 38-bit EX/MEM pipeline word and owns the 256 x 16 data memory, which services stores and loads.
- Registers load data, ALU result and write-back control into the 37-bit MEM/WB word.
- Reports its destination register and a post-reset memory-clear busy flag to the hazard detection unit.

Parameters:
- DATA_WIDTH, 16, width of ALU result, store data and memory words.
- ADDR_WIDTH, 8, data memory address width; address = ALU result[ADDR_WIDTH-1:0].
- DEPTH, 256, number of memory words (2^ADDR_WIDTH).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- pipeline_re_i  input  38  from EX. [37:22] alu_result; [21] mem_writ_en; [20:5] mem_writ_data; [4] wri_back_en; [3:1] wri_back_dest; [0] wri_back_result_mux (1 = load data, 0 = ALU result).
- pipeline_ou  output  37  to WB. [36:21] mem_read_data; [20:5] alu_result; [4:0] write-back control copied from input [4:0].
- mem_op_dest  output  3  pipeline_re_i[3:1], combinational, to hazard unit.
- mem_busy  output  1  high while the memory-clear sweep runs; the hazard unit stalls fetch/ID/EX while it is high.

Behaviour:
- Reset, on any rising edge with rst=1, including mid-sweep or mid-run:
  - pipeline_ou <= 0.
  - State <= CLEAR; clear counter <= 0; mem_busy = 1 at the next cycle.
  - Memory contents are not written in that cycle.
- CLEAR state:
  - Each cycle writes mem[clr_cnt] <= 0, then clr_cnt++.
  - After writing address DEPTH-1, state <= RUN; mem_busy deasserts the following cycle. Exactly DEPTH busy cycles after rst falls.
  - pipeline_re_i is ignored and pipeline_ou <= 0 (bubble) every CLEAR cycle.
- RUN state:
  - Store: if mem_writ_en=1, mem[alu_result[7:0]] <= mem_writ_data at the edge.
  - Load: mem_read_data = mem[alu_result[7:0]] is sampled at the same edge and registered into pipeline_ou[36:21]. The read is unconditional; WB selects via wri_back_result_mux.
  - Pipeline: pipeline_ou[20:5] <= alu_result and pipeline_ou[4:0] <= pipeline_re_i[4:0] every cycle. One-cycle latency, no stall input.
- Read-during-write, same address, same cycle: registered read data is the OLD contents (read-before-write). The new value is visible to a load on the next cycle.
- Address wrap: alu_result[15:8] is ignored, so alu_result 16'h0105 accesses word 5.
- NOP / bubble input (all zero) performs a read of address 0 and no write. Output carries mem_read_data = mem[0] and all control bits 0.
- mem_op_dest is purely combinational from the input and is valid in CLEAR as well.
- No X may reach pipeline_ou after reset: all memory words are defined by the sweep.

Test Plan:
- Reset/clear: assert rst 2 cycles, release → mem_busy=1 for exactly 256 cycles, pipeline_ou=0 throughout. Then load addr 8'h7F with wri_back_result_mux=1 → pipeline_ou[36:21]=16'h0000.
- Store then load: store 16'hBEEF to alu_result 16'h0010, next cycle load 16'h0010 with ctrl 5'b1_011_1 → one cycle later pipeline_ou = {16'hBEEF, 16'h0010, 5'b10111}.
- Read-during-write: mem[0x20]=16'h1111; store 16'h2222 to 0x20 in a single input word → that cycle's output read field = 16'h1111. Next-cycle load of 0x20 → 16'h2222.
- Address wrap: store 16'hA5A5 at alu_result 16'h0305, load 16'h0005 → 16'hA5A5.
- ALU pass-through: mem_writ_en=0, alu_result 16'h1234, ctrl 5'b1_101_0 → pipeline_ou[20:0] = {16'h1234, 5'b11010} one cycle later, memory unchanged. mem_op_dest = 3'b101 in the same cycle.
- Reset mid-sweep and mid-run: assert rst at clear cycle 100 → counter restarts, busy lasts 256 cycles from release. Assert rst in RUN with a pending store → store not performed, pipeline_ou=0.
